vx_barrier_ctrl: RTL and testbench

Per-core barrier scheduler. It consumes barrier requests decoded from the GPU unit's warp-control response (barrier id, participant count minus one, issuing warp id). It tracks arrivals per barrier, holds the stall mask for waiting warps, and emits a single release event carrying the warp mask to resume once the last participant arrives. It sits between the warp-control response path and the warp scheduler's stall/resume logic.

---
 rtl/vx_barrier_ctrl.sv | 157 +++++++++++++++
 tb/tb_vx_barrier_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/vx_barrier_ctrl.sv
// vx_barrier_ctrl: per-core barrier scheduler.
// Counts warp arrivals per barrier slot and parks the waiting warps. When the
// last participant arrives, it emits one registered release event that
// carries the mask of warps to resume. The release buffer holds one entry.
module vx_barrier_ctrl #(
  parameter int NUM_WARPS    = 4,
  parameter int NUM_BARRIERS = 4,
  parameter int NW_BITS      = $clog2(NUM_WARPS),
  parameter int NB_BITS      = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 bar_valid,
  output logic                 bar_ready,
  input  logic [NW_BITS-1:0]   bar_wid,
  input  logic [NB_BITS-1:0]   bar_id,
  input  logic [NW_BITS-1:0]   bar_size_m1,
  input  logic                 flush,
  output logic                 rel_valid,
  input  logic                 rel_ready,
  output logic [NB_BITS-1:0]   rel_id,
  output logic [NUM_WARPS-1:0] rel_wmask,
  output logic [NUM_WARPS-1:0] stalled_wmask,
  output logic                 err
);

  // Slot arrays are sized to the full id space. Ids that do not map to a
  // real barrier are rejected, so any extra slot stays idle.
  localparam int NB_SLOTS = 1 << NB_BITS;

  // Per-slot state
  logic [NB_SLOTS-1:0]                r_active;
  logic [NB_SLOTS-1:0][NW_BITS-1:0]   r_size;
  logic [NB_SLOTS-1:0][NW_BITS-1:0]   r_cnt;
  logic [NB_SLOTS-1:0][NUM_WARPS-1:0] r_wmask;

  // Single-entry release buffer and sticky error flag
  logic                 r_rel_valid;
  logic [NB_BITS-1:0]   r_rel_id;
  logic [NUM_WARPS-1:0] r_rel_wmask;
  logic                 r_err;

  // Decode of the current request
  logic                 w_bar_ready;
  logic                 w_take;
  logic                 w_bid_ok;
  logic                 w_slot_active;
  logic [NW_BITS-1:0]   w_slot_size;
  logic [NW_BITS-1:0]   w_slot_cnt;
  logic [NUM_WARPS-1:0] w_slot_wmask;
  logic [NUM_WARPS-1:0] w_wbit;
  logic [NW_BITS-1:0]   w_eff_size;
  logic                 w_dup;
  logic                 w_size_mis;
  logic                 w_other;
  logic                 w_last;
  logic                 w_upd;
  logic                 w_proto_err;
  logic [NUM_WARPS-1:0] w_stalled;

  // The scheduler may take a new arrival when the release buffer is empty
  // or is being drained in this same cycle.
  assign w_bar_ready = !r_rel_valid || rel_ready;

  // Any warp parked on an active slot is stalled.
  always_comb begin
    w_stalled = '0;
    for (int i = 0; i < NB_SLOTS; i++) begin
      w_stalled = w_stalled | (r_active[i] ? r_wmask[i] : '0);
    end
  end

  // Classify the arriving request against the addressed slot.
  always_comb begin
    w_take        = bar_valid && w_bar_ready && !flush;
    w_bid_ok      = ({1'b0, bar_id} < (NB_BITS + 1)'(NUM_BARRIERS));
    w_slot_active = r_active[bar_id];
    w_slot_size   = r_size[bar_id];
    w_slot_cnt    = r_cnt[bar_id];
    w_slot_wmask  = r_wmask[bar_id];
    w_wbit        = NUM_WARPS'(1'b1) << bar_wid;
    // The size latched by the first arrival wins over later requests.
    w_eff_size    = w_slot_active ? w_slot_size : bar_size_m1;
    w_dup         = |(w_slot_wmask & w_wbit);
    w_size_mis    = w_slot_active && (bar_size_m1 != w_slot_size);
    // The warp is already parked on a different barrier.
    w_other       = |(w_stalled & w_wbit & ~w_slot_wmask);
    w_last        = !w_dup && (w_slot_cnt == w_eff_size);
    w_upd         = w_take && w_bid_ok && !w_dup;
    w_proto_err   = w_take && (!w_bid_ok || w_dup || w_size_mis || w_other);
  end

  // Slot bookkeeping: record arrivals, clear a slot when it completes or on flush.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_active <= '0;
      r_size   <= '0;
      r_cnt    <= '0;
      r_wmask  <= '0;
    end else if (flush) begin
      r_active <= '0;
      r_size   <= '0;
      r_cnt    <= '0;
      r_wmask  <= '0;
    end else if (w_upd) begin
      if (w_last) begin
        r_active[bar_id] <= 1'b0;
        r_size[bar_id]   <= '0;
        r_cnt[bar_id]    <= '0;
        r_wmask[bar_id]  <= '0;
      end else begin
        r_active[bar_id] <= 1'b1;
        r_size[bar_id]   <= w_eff_size;
        r_cnt[bar_id]    <= w_slot_cnt + NW_BITS'(1'b1);
        r_wmask[bar_id]  <= w_slot_wmask | w_wbit;
      end
    end else begin
      r_active <= r_active;
    end
  end

  // Release buffer: load on a completing arrival, drop after the handshake.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rel_valid <= 1'b0;
      r_rel_id    <= '0;
      r_rel_wmask <= '0;
    end else if (w_upd && w_last) begin
      r_rel_valid <= 1'b1;
      r_rel_id    <= bar_id;
      r_rel_wmask <= w_slot_wmask | w_wbit;
    end else if (rel_ready) begin
      r_rel_valid <= 1'b0;
    end else begin
      r_rel_valid <= r_rel_valid;
    end
  end

  // Sticky protocol-error flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_err <= 1'b0;
    end else if (w_proto_err) begin
      r_err <= 1'b1;
    end else begin
      r_err <= r_err;
    end
  end

  assign bar_ready     = w_bar_ready;
  assign rel_valid     = r_rel_valid;
  assign rel_id        = r_rel_id;
  assign rel_wmask     = r_rel_wmask;
  assign stalled_wmask = w_stalled;
  assign err           = r_err;

endmodule

// File: tb/tb_vx_barrier_ctrl.sv
// tb_vx_barrier_ctrl: directed scoreboard bench for vx_barrier_ctrl.
// Each completing arrival pushes the expected release; a monitor pops and
// compares it at every release handshake.
module tb_vx_barrier_ctrl;

  logic       clk;
  logic       reset;
  logic       bar_valid;
  logic       bar_ready;
  logic [1:0] bar_wid;
  logic [1:0] bar_id;
  logic [1:0] bar_size_m1;
  logic       flush;
  logic       rel_valid;
  logic       rel_ready;
  logic [1:0] rel_id;
  logic [3:0] rel_wmask;
  logic [3:0] stalled_wmask;
  logic       err;

  typedef struct packed {
    logic [1:0] id;
    logic [3:0] wm;
  } rel_t;

  rel_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  vx_barrier_ctrl #(.NUM_WARPS(4), .NUM_BARRIERS(4)) dut (
    .clk(clk), .reset(reset),
    .bar_valid(bar_valid), .bar_ready(bar_ready),
    .bar_wid(bar_wid), .bar_id(bar_id), .bar_size_m1(bar_size_m1),
    .flush(flush),
    .rel_valid(rel_valid), .rel_ready(rel_ready),
    .rel_id(rel_id), .rel_wmask(rel_wmask),
    .stalled_wmask(stalled_wmask), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one arrival for a single cycle (the bench keeps bar_ready high here).
  task automatic arrive(input logic [1:0] id, input logic [1:0] wid, input logic [1:0] sz);
    bar_valid   = 1'b1;
    bar_id      = id;
    bar_wid     = wid;
    bar_size_m1 = sz;
    tick();
    bar_valid   = 1'b0;
  endtask

  task automatic expect_rel(input logic [1:0] id, input logic [3:0] wm);
    rel_t e;
    e.id = id;
    e.wm = wm;
    exp_q.push_back(e);
  endtask

  // Monitor: compare every accepted release against the scoreboard.
  initial begin
    rel_t e;
    forever begin
      @(negedge clk);
      if (reset && rel_valid && rel_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_release: got id=%0d wmask=%b expected none", rel_id, rel_wmask);
        end else begin
          e = exp_q.pop_front();
          chk("rel_id", int'(rel_id), int'(e.id));
          chk("rel_wmask", int'(rel_wmask), int'(e.wm));
        end
      end
    end
  end

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; bar_valid = 1'b0; bar_wid = 2'd0; bar_id = 2'd0;
    bar_size_m1 = 2'd0; flush = 1'b0; rel_ready = 1'b1;
    tick(); tick();
    reset = 1'b1;
    chk("rst_rel_valid", int'(rel_valid), 0);
    chk("rst_rel_id", int'(rel_id), 0);
    chk("rst_rel_wmask", int'(rel_wmask), 0);
    chk("rst_stalled", int'(stalled_wmask), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_bar_ready", int'(bar_ready), 1);

    // Basic 4-warp barrier on slot 1
    arrive(2'd1, 2'd0, 2'd3); chk("b4_stall0", int'(stalled_wmask), 4'b0001);
    arrive(2'd1, 2'd1, 2'd3); chk("b4_stall1", int'(stalled_wmask), 4'b0011);
    arrive(2'd1, 2'd2, 2'd3); chk("b4_stall2", int'(stalled_wmask), 4'b0111);
    chk("b4_no_rel", int'(rel_valid), 0);
    expect_rel(2'd1, 4'b1111);
    arrive(2'd1, 2'd3, 2'd3);
    chk("b4_rel_valid", int'(rel_valid), 1);
    chk("b4_stall3", int'(stalled_wmask), 4'b0000);
    tick();
    chk("b4_rel_done", int'(rel_valid), 0);

    // Single participant
    expect_rel(2'd0, 4'b0100);
    arrive(2'd0, 2'd2, 2'd0);
    chk("single_stall", int'(stalled_wmask), 4'b0000);
    chk("single_rel_valid", int'(rel_valid), 1);
    tick();

    // Backpressure on the release port
    rel_ready = 1'b0;
    arrive(2'd0, 2'd0, 2'd1); chk("bp_stall0", int'(stalled_wmask), 4'b0001);
    expect_rel(2'd0, 4'b0011);
    arrive(2'd0, 2'd1, 2'd1);
    bar_valid = 1'b1; bar_id = 2'd2; bar_wid = 2'd2; bar_size_m1 = 2'd1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_bar_ready", int'(bar_ready), 0);
      chk("bp_rel_valid", int'(rel_valid), 1);
      chk("bp_rel_id", int'(rel_id), 0);
      chk("bp_rel_wmask", int'(rel_wmask), 4'b0011);
      chk("bp_not_taken", int'(stalled_wmask), 4'b0000);
      tick();
    end
    rel_ready = 1'b1;
    tick();
    bar_valid = 1'b0;
    chk("bp_taken", int'(stalled_wmask), 4'b0100);
    chk("bp_drained", int'(rel_valid), 0);
    expect_rel(2'd2, 4'b1100);
    arrive(2'd2, 2'd3, 2'd1);
    tick();

    // Interleaved slots
    arrive(2'd0, 2'd0, 2'd1); chk("il_stall0", int'(stalled_wmask), 4'b0001);
    arrive(2'd1, 2'd1, 2'd1); chk("il_stall1", int'(stalled_wmask), 4'b0011);
    expect_rel(2'd1, 4'b0110);
    arrive(2'd1, 2'd2, 2'd1); chk("il_stall2", int'(stalled_wmask), 4'b0001);
    expect_rel(2'd0, 4'b1001);
    arrive(2'd0, 2'd3, 2'd1); chk("il_stall3", int'(stalled_wmask), 4'b0000);
    chk("il_rel_id", int'(rel_id), 0);
    tick();

    // Duplicate arrival and size mismatch
    chk("er_pre", int'(err), 0);
    arrive(2'd0, 2'd0, 2'd2); chk("er_stall0", int'(stalled_wmask), 4'b0001);
    chk("er_clean", int'(err), 0);
    arrive(2'd0, 2'd0, 2'd2); chk("er_dup_stall", int'(stalled_wmask), 4'b0001);
    chk("er_dup_err", int'(err), 1);
    arrive(2'd0, 2'd1, 2'd1); chk("er_mis_stall", int'(stalled_wmask), 4'b0011);
    chk("er_mis_norel", int'(rel_valid), 0);
    expect_rel(2'd0, 4'b0111);
    arrive(2'd0, 2'd2, 2'd2);
    chk("er_rel_valid", int'(rel_valid), 1);
    tick();
    chk("er_sticky", int'(err), 1);

    // Flush mid-operation, with a request dropped in the flush cycle
    arrive(2'd3, 2'd0, 2'd2);
    arrive(2'd3, 2'd1, 2'd2); chk("fl_pre", int'(stalled_wmask), 4'b0011);
    flush = 1'b1; bar_valid = 1'b1; bar_id = 2'd3; bar_wid = 2'd2; bar_size_m1 = 2'd2;
    tick();
    flush = 1'b0; bar_valid = 1'b0;
    chk("fl_stall", int'(stalled_wmask), 4'b0000);
    chk("fl_norel", int'(rel_valid), 0);
    arrive(2'd3, 2'd2, 2'd1); chk("fl_new0", int'(stalled_wmask), 4'b0100);
    expect_rel(2'd3, 4'b0101);
    arrive(2'd3, 2'd0, 2'd1);
    tick();
    chk("fl_err_sticky", int'(err), 1);

    // Reset mid-operation with a release pending
    rel_ready = 1'b0;
    arrive(2'd2, 2'd0, 2'd3);
    arrive(2'd2, 2'd1, 2'd3);
    arrive(2'd0, 2'd3, 2'd0);
    chk("mr_rel_valid", int'(rel_valid), 1);
    chk("mr_rel_wmask", int'(rel_wmask), 4'b1000);
    chk("mr_stall", int'(stalled_wmask), 4'b0011);
    chk("mr_bar_ready", int'(bar_ready), 0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("mr_rst_rel_valid", int'(rel_valid), 0);
    chk("mr_rst_rel_id", int'(rel_id), 0);
    chk("mr_rst_rel_wmask", int'(rel_wmask), 0);
    chk("mr_rst_stall", int'(stalled_wmask), 0);
    chk("mr_rst_err", int'(err), 0);
    chk("mr_rst_bar_ready", int'(bar_ready), 1);
    rel_ready = 1'b1;
    arrive(2'd2, 2'd1, 2'd1); chk("mr_new0", int'(stalled_wmask), 4'b0010);
    expect_rel(2'd2, 4'b0011);
    arrive(2'd2, 2'd0, 2'd1);
    tick(); tick();
    chk("mr_err_clean", int'(err), 0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
